// File: rtl/serial_frame_rx.sv
// serial_frame_rx: receives start/data(LSB first)/[parity]/stop frames, one bit per clock.
// Ports: ck clock (rising edge); rst_n sync active-low reset; sin serial line, idles high;
//        dout last well-framed word; dvalid one-cycle pulse when dout updates;
//        perr one-cycle parity-mismatch pulse with dvalid; ferr one-cycle pulse when stop bit is 0;
//        busy high whenever the receiver is not idle.
module serial_frame_rx #(
  parameter int DW = 8,
  parameter int PARITY_EN = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          sin,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  output logic          perr,
  output logic          ferr,
  output logic          busy
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DATA = 3'd1;
  localparam logic [2:0] PAR  = 3'd2;
  localparam logic [2:0] STOP = 3'd3;
  localparam logic [2:0] BRK  = 3'd4;
  localparam logic [4:0] LAST = 5'(DW - 1);
  localparam logic       ODD  = (PARITY_ODD != 0);
  localparam logic       PEN  = (PARITY_EN != 0);
  logic [2:0]    state;
  logic [DW-1:0] sh;
  logic [4:0]    cnt;
  logic          acc, pbit;
  assign busy = (state != IDLE);
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      acc    <= 1'b0;
      pbit   <= 1'b0;
      dout   <= '0;
      dvalid <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      dvalid <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
      case (state)
        IDLE: if (!sin) begin
          state <= DATA;
          cnt   <= '0;
          acc   <= 1'b0;
          pbit  <= 1'b0;
        end
        DATA: begin
          // Bits arrive LSB first, so shifting in at the MSB leaves D0 at bit 0 after DW bits.
          sh    <= {sin, sh[DW-1:1]};
          acc   <= acc ^ sin;
          cnt   <= cnt + 5'd1;
          state <= (cnt == LAST) ? (PEN ? PAR : STOP) : DATA;
        end
        PAR: begin
          pbit  <= sin;
          state <= STOP;
        end
        STOP: if (sin) begin
          dout   <= sh;
          dvalid <= 1'b1;
          perr   <= PEN & (acc ^ pbit ^ ODD);
          state  <= IDLE;
        end else begin
          // Framing error wins over parity: no data, no perr, wait for the line to recover.
          ferr  <= 1'b1;
          state <= BRK;
        end
        BRK: state <= sin ? IDLE : BRK;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
